// File: rtl/pong_pkg.sv
// Shared widths, quadrature phase encodings and the signed clamp used by the
// bat input front end.
package pong_pkg;

    localparam int MOVE_W = 9;
    localparam int ACC_W  = 10;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_t;

    // Clamp v into [-lim, +lim]; the two guard bits on v absorb one add.
    function automatic logic signed [ACC_W-1:0] sat_signed(
        input logic signed [ACC_W+1:0] v,
        input logic signed [ACC_W+1:0] lim
    );
        logic signed [ACC_W+1:0] r;
        if (v > lim) begin
            r = lim;
        end else if (v < -lim) begin
            r = -lim;
        end else begin
            r = v;
        end
        return r[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature step decoder: compares the synced phases with last clock's
// phases and flags one step per legal single-bit transition.
module quad_decoder
    import pong_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic step_valid,
    output logic step_dir
);

    logic [1:0] prev_q;
    logic [1:0] prev_d;
    logic [1:0] cur;

    always_comb begin
        cur        = {a, b};
        prev_d     = cur;
        step_valid = 1'b0;
        step_dir   = 1'b0;
        // step_dir=1 follows 00->01->11->10->00; double-bit jumps fall through
        case (prev_q)
            Q00: begin
                if (cur == Q01) begin
                    step_valid = 1'b1;
                    step_dir   = 1'b1;
                end else if (cur == Q10) begin
                    step_valid = 1'b1;
                end
            end
            Q01: begin
                if (cur == Q11) begin
                    step_valid = 1'b1;
                    step_dir   = 1'b1;
                end else if (cur == Q00) begin
                    step_valid = 1'b1;
                end
            end
            Q11: begin
                if (cur == Q10) begin
                    step_valid = 1'b1;
                    step_dir   = 1'b1;
                end else if (cur == Q01) begin
                    step_valid = 1'b1;
                end
            end
            default: begin
                if (cur == Q00) begin
                    step_valid = 1'b1;
                    step_dir   = 1'b1;
                end else if (cur == Q11) begin
                    step_valid = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= Q00;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/bat_move_accum.sv
// Per-bat input front end: encoder and buttons become one signed move delta
// per frame, latched on vsync fall, plus a human-presence flag with timeout.
module bat_move_accum
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ENC_SHIFT   = 1,
    parameter int BTN_STEP    = 4,
    parameter int MAX_MOVE    = 127,
    parameter int IDLE_FRAMES = 500
) (
    input  logic                     glb_clk,
    input  logic                     reset,
    input  logic                     enc_a,
    input  logic                     enc_b,
    input  logic                     btn_up_n,
    input  logic                     btn_down_n,
    input  logic                     vsync,
    output logic signed [MOVE_W-1:0] move,
    output logic                     human
);

    localparam int IDLE_W = $clog2(IDLE_FRAMES + 1);
    localparam logic signed [ACC_W+1:0] ENC_INC = (ACC_W+2)'(1 << ENC_SHIFT);
    localparam logic signed [ACC_W+1:0] BTN_INC = (ACC_W+2)'(BTN_STEP);
    localparam logic signed [ACC_W+1:0] LIM     = (ACC_W+2)'(MAX_MOVE);
    localparam logic [IDLE_W-1:0]       IDLE_MAX = IDLE_W'(IDLE_FRAMES);
    // Synchronizer lane order {enc_a, enc_b, btn_up_n, btn_down_n}; buttons idle high
    localparam logic [3:0]              SYNC_RST = 4'b0011;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic                        vsync_dly_q, vsync_dly_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [MOVE_W-1:0]    move_q, move_d;
    logic                        human_q, human_d;
    logic [IDLE_W-1:0]           idle_q, idle_d;
    logic                        act_seen_q, act_seen_d;

    logic                        enc_a_s, enc_b_s, up_pressed, down_pressed;
    logic                        step_valid, step_dir;
    logic                        fe, activity;
    logic signed [ACC_W+1:0]     acc_ext, step_val, btn_val;
    logic signed [ACC_W-1:0]     move_full;

    always_comb begin
        sync_d[0] = {enc_a, enc_b, btn_up_n, btn_down_n};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        vsync_dly_d = vsync;
    end

    assign enc_a_s      = sync_q[SYNC_STAGES-1][3];
    assign enc_b_s      = sync_q[SYNC_STAGES-1][2];
    assign up_pressed   = ~sync_q[SYNC_STAGES-1][1];
    assign down_pressed = ~sync_q[SYNC_STAGES-1][0];
    assign fe           = vsync_dly_q & ~vsync;

    quad_decoder u_quad (
        .clk        (glb_clk),
        .rst        (reset),
        .a          (enc_a_s),
        .b          (enc_b_s),
        .step_valid (step_valid),
        .step_dir   (step_dir)
    );

    // Accumulate encoder steps; on frame event publish acc+buttons and restart
    always_comb begin
        acc_ext   = {{2{acc_q[ACC_W-1]}}, acc_q};
        step_val  = step_dir ? ENC_INC : -ENC_INC;
        btn_val   = '0;
        if (up_pressed && !down_pressed) begin
            btn_val = BTN_INC;
        end else if (down_pressed && !up_pressed) begin
            btn_val = -BTN_INC;
        end
        move_full = sat_signed(acc_ext + btn_val, LIM);
        acc_d     = acc_q;
        move_d    = move_q;
        if (fe) begin
            move_d = move_full[MOVE_W-1:0];
            acc_d  = step_valid ? sat_signed(step_val, LIM) : '0;
        end else if (step_valid) begin
            acc_d  = sat_signed(acc_ext + step_val, LIM);
        end
    end

    // A step coinciding with fe belongs to the next frame, so it re-arms act_seen
    always_comb begin
        activity   = step_valid | up_pressed | down_pressed;
        act_seen_d = fe ? activity : (act_seen_q | activity);
        idle_d     = idle_q;
        human_d    = human_q;
        if (activity) begin
            human_d = 1'b1;
            idle_d  = '0;
        end else if (fe && !act_seen_q && idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
            if (idle_q + IDLE_W'(1) == IDLE_MAX) begin
                human_d = 1'b0;
            end
        end
    end

    always_ff @(posedge glb_clk) begin
        if (reset) begin
            sync_q      <= {SYNC_STAGES{SYNC_RST}};
            vsync_dly_q <= 1'b1;
            acc_q       <= '0;
            move_q      <= '0;
            human_q     <= 1'b0;
            idle_q      <= '0;
            act_seen_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            vsync_dly_q <= vsync_dly_d;
            acc_q       <= acc_d;
            move_q      <= move_d;
            human_q     <= human_d;
            idle_q      <= idle_d;
            act_seen_q  <= act_seen_d;
        end
    end

    assign move  = move_q;
    assign human = human_q;

endmodule

// File: tb/tb_bat_move_accum.sv
// Directed bench for bat_move_accum: encoder, buttons, saturation, illegal
// transitions, fe-coincident steps, human timeout and mid-frame reset.
module tb_bat_move_accum;

    logic              glb_clk = 1'b0;
    logic              reset, enc_a, enc_b, btn_up_n, btn_down_n, vsync;
    logic signed [8:0] move;
    logic              human;
    logic [1:0]        ab;
    int                vectors = 0;
    int                miscompares = 0;

    always #5 glb_clk = ~glb_clk;

    bat_move_accum dut (
        .glb_clk    (glb_clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .vsync      (vsync),
        .move       (move),
        .human      (human)
    );

    task automatic tick();
        @(posedge glb_clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic set_ab(input logic [1:0] v);
        ab = v;
        {enc_a, enc_b} = v;
        tick();
    endtask

    function automatic logic [1:0] cw_next(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ccw_next(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1; ab = 2'b00;
        enc_a = 1'b0; enc_b = 1'b0; btn_up_n = 1'b1; btn_down_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_move", move, 9'h000);
        chk("reset_human", {8'h00, human}, 9'h000);

        frame();
        chk("idle_first_move", move, 9'h000);
        chk("idle_first_human", {8'h00, human}, 9'h000);

        for (int i = 0; i < 12; i++) set_ab(cw_next(ab));
        settle();
        frame();
        chk("cw12_move", move, 9'h018);
        chk("cw12_human", {8'h00, human}, 9'h001);
        frame();
        chk("cw12_next_idle", move, 9'h000);

        for (int i = 0; i < 200; i++) set_ab(ccw_next(ab));
        settle();
        frame();
        chk("ccw200_sat", move, 9'h181);

        for (int i = 0; i < 72; i++) set_ab(cw_next(ab));
        settle();
        frame();
        chk("cw72_sat", move, 9'h07F);

        btn_up_n = 1'b0;
        settle();
        frame();
        chk("btn_up_f1", move, 9'h004);
        frame();
        chk("btn_up_f2", move, 9'h004);
        btn_down_n = 1'b0;
        settle();
        frame();
        chk("btn_both", move, 9'h000);
        btn_up_n = 1'b1;
        settle();
        frame();
        chk("btn_down", move, 9'h1FC);
        btn_down_n = 1'b1;
        settle();
        frame();
        chk("btn_released", move, 9'h000);

        set_ab(2'b11);
        settle();
        frame();
        chk("illegal_jump", move, 9'h000);

        // Step reaches the decoder on the same clock vsync falls
        ab = cw_next(ab);
        {enc_a, enc_b} = ab;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        chk("coincident_fe", move, 9'h000);
        vsync = 1'b1;
        tick();
        settle();
        frame();
        chk("coincident_next", move, 9'h002);

        btn_up_n = 1'b0;
        repeat (3) tick();
        btn_up_n = 1'b1;
        settle();
        frame();
        chk("pre_timeout_move", move, 9'h000);
        chk("pre_timeout_human", {8'h00, human}, 9'h001);
        repeat (499) frame();
        chk("timeout_499", {8'h00, human}, 9'h001);
        frame();
        chk("timeout_500", {8'h00, human}, 9'h000);
        frame();
        chk("timeout_sat", {8'h00, human}, 9'h000);

        ab = cw_next(ab);
        {enc_a, enc_b} = ab;
        tick();
        chk("rehuman_c1", {8'h00, human}, 9'h000);
        tick();
        chk("rehuman_c2", {8'h00, human}, 9'h000);
        tick();
        chk("rehuman_c3", {8'h00, human}, 9'h001);
        settle();

        for (int i = 0; i < 4; i++) set_ab(cw_next(ab));
        settle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_move", move, 9'h000);
        chk("midreset_human", {8'h00, human}, 9'h000);
        tick();
        set_ab(cw_next(ab));
        settle();
        frame();
        chk("post_reset_move", move, 9'h002);
        chk("post_reset_human", {8'h00, human}, 9'h001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bat_move_accum.md
Name: bat_move_accum

Overview:
Per-bat input front end that drives the game core's `bat_move` and `bat_human` inputs (one instance per side).
- Decodes a quadrature rotary encoder and a pair of up/down buttons into one signed movement delta per video frame.
- The delta is latched at the start of vsync, so it is stable when the game core samples it at the rising vsync edge.
- Drops the human flag after a period of no input, which hands the bat back to the autoplayer.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers for encoder and button pins
ENC_SHIFT, 1, each valid encoder step contributes ±(1<<ENC_SHIFT)
BTN_STEP, 4, per-frame delta while one button is held
MAX_MOVE, 127, output and accumulator saturation magnitude (≤255)
IDLE_FRAMES, 500, frames without activity before human drops (10 s at 50 Hz)

Ports:
glb_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enc_a  in  1  encoder phase A, asynchronous pin
enc_b  in  1  encoder phase B, asynchronous pin
btn_up_n  in  1  up button, active-low, asynchronous
btn_down_n  in  1  down button, active-low, asynchronous
vsync  in  1  negative vsync from the game core, glb_clk domain
move  out  9  signed two's-complement delta; positive moves the bat up (the core subtracts it from ypos)
human  out  1  1 while a player is active; drives the core's bat_human input

Behaviour:
- Clocking and reset: one clock (glb_clk); reset is synchronous and active-high.
- Reset values:
  - move=0, human=0, accumulator=0, idle counter=0.
  - Encoder synchronizers and the previous-phase register = 2'b00.
  - Button synchronizers = 1 (released).
  - vsync delay register = 1.
- Synchronizers: SYNC_STAGES flops on enc_a, enc_b, btn_up_n and btn_down_n. vsync is already in the glb_clk domain; it gets a single delay register used only for edge detection.
- Frame event: fe = vsync_d & ~vsync, i.e. the falling edge of vsync, asserted for one clock.
- Quadrature decoding:
  - Compare the synced {a,b} with the previous {a,b} every clock.
  - Sequence 00→01→11→10→00 is +1 (up); the reverse sequence is −1.
  - No change gives no step.
  - An illegal transition (both bits change) gives no step, but the previous-phase register is still updated.
- Accumulator:
  - 10-bit signed.
  - A valid step adds ±(1<<ENC_SHIFT), saturating at ±MAX_MOVE, so it never wraps.
- Frame event handling, registered, one-clock latency after fe:
  - btn = +BTN_STEP if only up is held, −BTN_STEP if only down is held, 0 if neither or both are held.
  - move <= sat(acc + btn, ±MAX_MOVE), sign-extended/truncated to 9 bits.
  - acc <= step of this same clock, or 0 if there is none. A step that coincides with fe is never lost; it counts toward the next frame.
- move holds its value between frame events.
- Activity is any valid encoder step, or any clock on which a synced button reads pressed.
- Human flag:
  - Activity → human <= 1 and idle counter <= 0, on the next clock.
  - fe with no activity since the previous fe → idle++.
  - When idle reaches IDLE_FRAMES → human <= 0; idle saturates at that value.
  - move is still produced while human=0 (the core ignores it).
- Reset mid-frame: all state clears. The next fe outputs only activity seen after reset.

Decomposition:
- pong_pkg holds MOVE_W=9, the 2-bit quadrature-state encoding constants (Q00, Q01, Q11, Q10), and the signed saturation helper function.
- Sub-module quad_decoder:
  - Inputs: synced a and b.
  - Outputs: step_valid and step_dir.
  - Contains the previous-phase register and the illegal-transition filter.
- Synchronizer chains and the accumulate/latch/idle logic stay in bat_move_accum.

Test Plan:
- Reset asserted for 3 clocks then released → move=9'h000, human=0. First fe with no stimulus → move stays 0.
- 12 CW encoder transitions (3 full cycles) within one frame, ENC_SHIFT=1, then fe → move=9'h018 (+24) one clock after fe, human=1. Next frame idle → move=9'h000.
- 200 CCW transitions within one frame → move=9'h181 (−127); the accumulator does not wrap.
- btn_up_n held low across 2 frames → move=+4 at each fe. Both buttons low → move=0. btn_down_n low alone → move=9'h1FC (−4).
- Illegal 00→11 transition → no step (move=0 at next fe). A CW step on the same clock as fe → excluded from that frame, next fe gives move=+2.
- Human timeout: human=1, then 500 frames with no input → human falls at the 500th fe. A single encoder step afterwards → human=1 again, SYNC_STAGES+1 clocks after the pin edge.
